hazard_tracker: RTL
===================

# hazard_tracker

Destination-tracking pipeline for the 5-stage core. It shadows the ID/EX, EX/MEM and MEM/WB register-write information and drives the source and destination tags consumed by the forwarding unit. It also detects load-use hazards and drives the stall request. The block sits between the decode stage and the forwarding unit, which is instantiated with its width parameter set to ADDR_W+1 so that it compares tags rather than raw register numbers.

## Interface
Parameters:
- ADDR_W, 5, register-number width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  core clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  the ID stage holds a real instruction.
- id_rs  input  ADDR_W  first source register of the ID instruction.
- id_rt  input  ADDR_W  second source register of the ID instruction.
- id_rd  input  ADDR_W  destination register of the ID instruction, after the rt/rd destination mux.
- id_reg_write  input  1  the ID instruction writes the register file.
- id_mem_read  input  1  the ID instruction is a load.
- flush  input  1  branch/jump taken; kills the instruction entering EX.
- stall  output  1  load-use stall request to PC and IF/ID (combinational).
- ex_rs_tag  output  ADDR_W+1  Rs tag of the EX instruction.
- ex_rt_tag  output  ADDR_W+1  Rt tag of the EX instruction.
- rd_ex_mem_tag  output  ADDR_W+1  destination tag of the MEM-stage instruction.
- rd_mem_wb_tag  output  ADDR_W+1  destination tag of the WB-stage instruction.
- stall_count  output  CNT_W  saturating count of stall cycles.

## Operation
- Tag encoding:
  - Source tag is {1'b1, reg} for reg != 0, else all-zero.
  - Destination tag is {1'b1, rd} when the slot is valid, reg_write = 1 and rd != 0; otherwise {1'b0, all-ones} (the "none" tag).
  - A source tag therefore never matches the none tag, and $0 is never forwarded.
- Slots:
  - EX slot holds {valid, rs, rt, rd, reg_write, mem_read}.
  - MEM slot holds {valid, rd, reg_write}.
  - WB slot holds {valid, rd, reg_write}.
  - A bubble is valid = 0, with all other fields 0.
- Load-use:
  - stall = id_valid & EX.valid & EX.mem_read & (EX.rd != 0) & (EX.rd == id_rs | EX.rd == id_rt) & ~flush.
- EX slot update, in priority order:
  - flush: load a bubble.
  - stall: load a bubble.
  - otherwise: capture the ID inputs, with valid = id_valid.
- The MEM slot always captures the EX slot. The WB slot always captures the MEM slot.
- stall_count increments by 1 on every rising edge where stall = 1. It saturates at 2^CNT_W-1 and never wraps.
- The upstream stages hold IF/ID and PC while stall = 1. This block holds no ID state of its own.

## Timing
- An instruction in ID during cycle n:
  - appears on ex_rs_tag/ex_rt_tag in cycle n+1;
  - appears on rd_ex_mem_tag in cycle n+2;
  - appears on rd_mem_wb_tag in cycle n+3.
- Back-to-back dependent ALU ops have zero stall: the consumer's EX cycle sees the producer on rd_ex_mem_tag.
- Load followed by a dependent instruction:
  - exactly one stall cycle;
  - the consumer enters EX two cycles after the load and sees the load on rd_mem_wb_tag.
- stall is combinational within the cycle and carries no register delay.
- Reset (asynchronous, any cycle, including mid-stall):
  - all slots become bubbles;
  - ex_rs_tag = ex_rt_tag = 0;
  - rd_ex_mem_tag = rd_mem_wb_tag = none tag (6'h1F for ADDR_W = 5);
  - stall = 0 and stall_count = 0.
- After arst_n deasserts, the first capture happens on the next rising edge.
- flush and stall in the same cycle: stall output is 0, the EX slot gets a bubble, and the counter does not increment.
- id_valid = 0: no stall, and the EX slot receives a bubble.

## Test plan
- Reset: assert arst_n = 0 mid-stream while a load-use stall is active -> the same cycle shows stall = 0, both rd tags = 6'h1F, ex tags = 0 and stall_count = 0.
- ALU dependency: add $3 at cycle n, then sub $4,$3,$5 -> stall stays 0; at n+2, ex_rs_tag = 6'h23 and rd_ex_mem_tag = 6'h23.
- Load-use: lw $3 at n, then add $4,$3,$5 -> stall = 1 in cycle n+1 only; EX holds a bubble at n+2; at n+3, ex_rs_tag = 6'h23, rd_mem_wb_tag = 6'h23 and stall_count = 1.
- $0 destination: addi $0 followed by an instruction reading $0 -> rd_ex_mem_tag = 6'h1F, ex_rs_tag = 6'h00, never equal.
- Flush priority: a load-use condition with flush = 1 in the same cycle -> stall = 0, the EX slot is a bubble, and stall_count is unchanged.
- Saturation: CNT_W = 4 with 20 consecutive load-use stalls -> stall_count stops at 15 and stays at 15.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// Decode-side bundle between the ID stage, hazard_tracker and the forwarding unit.
// master drives ID information and consumes tags; slave is the tracker itself.
interface hazard_tracker_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [ADDR_W-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic              stall;
    logic [ADDR_W:0]   ex_rs_tag;
    logic [ADDR_W:0]   ex_rt_tag;
    logic [ADDR_W:0]   rd_ex_mem_tag;
    logic [ADDR_W:0]   rd_mem_wb_tag;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush,
        input  stall, ex_rs_tag, ex_rt_tag, rd_ex_mem_tag, rd_mem_wb_tag, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush,
        output stall, ex_rs_tag, ex_rt_tag, rd_ex_mem_tag, rd_mem_wb_tag, stall_count
    );
endinterface

// File: rtl/hazard_tracker.sv
// Shadows ID/EX, EX/MEM and MEM/WB write info, emits forwarding tags and
// raises a load-use stall with a saturating stall-cycle counter.
module hazard_tracker #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic              clk,
    input logic              arst_n,
    hazard_tracker_if.slave  bus
);
    localparam logic [ADDR_W:0] NoneTag = {1'b0, {ADDR_W{1'b1}}};

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [ADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_mr_q, ex_mr_d;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_rd_q;
    logic              mem_rw_q;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic              wb_rw_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall;

    // Flush masks the stall so a killed load-use pair costs no extra cycle.
    always_comb begin
        stall = bus.id_valid & ex_valid_q & ex_mr_q & (ex_rd_q != '0) &
                ((ex_rd_q == bus.id_rs) | (ex_rd_q == bus.id_rt)) & ~bus.flush;
    end

    always_comb begin
        ex_valid_d = bus.id_valid;
        ex_rs_d    = bus.id_rs;
        ex_rt_d    = bus.id_rt;
        ex_rd_d    = bus.id_rd;
        ex_rw_d    = bus.id_reg_write;
        ex_mr_d    = bus.id_mem_read;
        if (bus.flush || stall || !bus.id_valid) begin
            ex_valid_d = 1'b0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_rd_d    = '0;
            ex_rw_d    = 1'b0;
            ex_mr_d    = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= ex_valid_q;
            mem_rd_q    <= ex_rd_q;
            mem_rw_q    <= ex_rw_q;
            wb_valid_q  <= mem_valid_q;
            wb_rd_q     <= mem_rd_q;
            wb_rw_q     <= mem_rw_q;
            cnt_q       <= cnt_d;
        end
    end

    // Tag MSB keeps $0 sources and "no writer" destinations from ever matching.
    always_comb begin
        bus.stall         = stall;
        bus.ex_rs_tag     = (ex_rs_q != '0) ? {1'b1, ex_rs_q} : '0;
        bus.ex_rt_tag     = (ex_rt_q != '0) ? {1'b1, ex_rt_q} : '0;
        bus.rd_ex_mem_tag = (mem_valid_q && mem_rw_q && (mem_rd_q != '0)) ?
                            {1'b1, mem_rd_q} : NoneTag;
        bus.rd_mem_wb_tag = (wb_valid_q && wb_rw_q && (wb_rd_q != '0)) ?
                            {1'b1, wb_rd_q} : NoneTag;
        bus.stall_count   = cnt_q;
    end
endmodule
